// File: rtl/switch_pkg.sv
// Shared switch definitions: default port count, word width, statistics
// counter width and the output-arbiter FSM state encoding.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 33;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    // Width of a port index; a single-port build still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector. Scans the request
// vector starting at the port just after last_grant, so the port granted
// last has the lowest priority. When last_grant is the only requester it
// is reached at the end of the scan and therefore re-granted.
module rr_pick
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     sel,
    output logic                 any_req
);

    logic [IDX_W-1:0] cand_s;
    logic [IDX_W-1:0] sel_s;
    logic             hit_s;
    logic             found_s;

    // Walk the ring once from last_grant+1; the first requester seen wins.
    always_comb begin
        cand_s  = last_grant;
        sel_s   = {IDX_W{1'b0}};
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand_s  = IDX_W'((int'(last_grant) + off) % NUM_PORTS);
            hit_s   = req[cand_s] & ~found_s;
            sel_s   = hit_s ? cand_s : sel_s;
            found_s = found_s | hit_s;
        end
    end

    assign sel     = sel_s;
    assign any_req = |req;

endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin drain of NUM_PORTS input queues onto one
// output port, one word in flight at a time (IDLE -> FETCH -> HOLD).
// q_rd_en is decoded combinationally in IDLE so the queue pops on the same
// edge the FSM leaves IDLE; the popped word is captured in FETCH and held
// in HOLD until the consumer takes it.
// Optional build macro: ARB_STATS_EN adds grant_cnt, one 16-bit wrapping
// handoff counter per port.
module output_arbiter
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
    parameter int DATA_W    = switch_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        q_empty,
    output logic [NUM_PORTS-1:0]        q_rd_en,
    input  logic [NUM_PORTS*DATA_W-1:0] q_rd_data,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0]  grant_cnt
`endif
);

    localparam int               IDX_W     = idx_width(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_PORTS - 1);

    arb_state_t             state_r;
    arb_state_t             state_nxt_s;
    logic [IDX_W-1:0]       last_grant_r;
    logic [IDX_W-1:0]       sel_r;
    logic [IDX_W-1:0]       pick_sel_s;
    logic                   any_req_s;
    logic [NUM_PORTS-1:0]   rd_en_s;
    logic                   load_sel_s;
    logic                   capture_s;
    logic                   release_s;
    logic [DATA_W-1:0]      out_data_r;
    logic                   out_valid_r;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req        (~q_empty),
        .last_grant (last_grant_r),
        .sel        (pick_sel_s),
        .any_req    (any_req_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus the one-cycle read strobe and datapath enables.
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = {NUM_PORTS{1'b0}};
        load_sel_s  = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    rd_en_s[pick_sel_s] = 1'b1;
                    load_sel_s          = 1'b1;
                    state_nxt_s         = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                capture_s   = 1'b1;
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A reset cycle must not pop a queue, even if the FSM sits in IDLE.
    assign q_rd_en = rst ? {NUM_PORTS{1'b0}} : rd_en_s;

    // Remember the port being served; it becomes last_grant only on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r        <= {IDX_W{1'b0}};
            last_grant_r <= LAST_INIT;
        end else begin
            if (load_sel_s) begin
                sel_r <= pick_sel_s;
            end else begin
                sel_r <= sel_r;
            end
            if (release_s) begin
                last_grant_r <= sel_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Output word register: load in FETCH, hold in HOLD, drop valid on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_data_r  <= q_rd_data[int'(sel_r)*DATA_W +: DATA_W];
            out_valid_r <= 1'b1;
        end else if (release_s) begin
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [NUM_PORTS];

    // Per-port handoff counters; the 16-bit add wraps 65535 -> 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (release_s && (sel_r == IDX_W'(i))) begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_r[gi];
    end
`endif

endmodule
